uart_bus_bridge: RTL and testbench
==================================

Name: uart_bus_bridge

Overview:
- Debug and load bridge: receives command frames as a byte stream from the UART receiver and performs 32-bit accesses as an initiator on the CPU data bus.
- Returns ack or read data bytes to the UART transmitter.
- Sits beside the CPU in top; an external arbiter grants it the data bus.
- Used to load programs into RAM and to peek or poke IO without the boot ROM.

Parameters:
- RD_LATENCY, 2, bus cycles from o_rd assertion to valid i_data_rd; range 1..7.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout inside a frame, in i_clk cycles.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  transmit request; held until accepted.
- i_tx_ready  in  1  transmitter accepts the byte when o_tx_valid && i_tx_ready.
- o_bus_req  out  1  bus request to the arbiter.
- i_bus_gnt  in  1  bus grant.
- o_addr  out  32  bus address.
- o_data_wr  out  32  write data.
- o_wr  out  4  byte write strobes.
- o_rd  out  1  read strobe.
- i_data_rd  in  32  read data.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; byte counter 0; timeout counter 0.
- Frame formats (all multi-byte fields little-endian):
  - 'W' (0x57), addr[4], data[4]: bus write; response is 0x06.
  - 'R' (0x52), addr[4]: bus read; response is 4 data bytes, LSB first.
  - Any other first byte: respond 0x15 (NAK), then return to IDLE.
- States:
  - IDLE: on i_rx_valid, decode the command byte. 'W' or 'R' -> ADDR; else -> RESP with NAK.
  - ADDR: collect 4 bytes into the address register. After the 4th byte: 'W' -> DATA, 'R' -> REQ.
  - DATA: collect 4 bytes, then -> REQ.
  - REQ: assert o_bus_req. When i_bus_gnt is sampled high -> ACCESS. o_bus_req stays high until the exit from ACCESS/WAIT_RD.
  - ACCESS, one cycle, with o_addr driven:
    - Write: o_wr=4'hF, o_data_wr=data; -> RESP with ack.
    - Read: o_rd=1; -> WAIT_RD.
  - WAIT_RD: hold o_rd and o_addr. Capture i_data_rd exactly RD_LATENCY cycles after the ACCESS cycle, then drop o_rd and o_bus_req; -> RESP.
  - RESP: present bytes in order on o_tx_valid/o_tx_data. Advance one byte per accepted handshake. After the last byte -> IDLE.
- Bus rules:
  - o_wr and o_rd are never asserted without i_bus_gnt.
  - o_wr is high for exactly one cycle per write.
  - o_addr and o_data_wr hold their values for the whole access.
- Grant loss: if i_bus_gnt drops during ACCESS/WAIT_RD, the access completes regardless. The arbiter must not revoke the grant mid-access.
- Timeout:
  - In ADDR/DATA, the counter resets on each i_rx_valid.
  - At TIMEOUT_CYCLES with no new byte: -> IDLE, no response, partial frame discarded.
- Bytes arriving outside IDLE/ADDR/DATA (during REQ, ACCESS, WAIT_RD or RESP) are dropped silently.
- i_rx_valid coinciding with the timeout expiry cycle: the byte wins and the counter resets.
- Reset asserted mid-frame or mid-access: immediate return to reset values. Any in-flight bus strobe drops asynchronously.
- The address is used as given; no alignment check. o_addr[1:0] are passed through.

Optional Feature:
- Macro: UART_BUS_BRIDGE_CPU_HOLD_EN.
- Defined:
  - Adds output o_cpu_hold (1 bit, reset 0).
  - o_cpu_hold goes high on the cycle the first frame byte is accepted in IDLE; no hold for NAK frames.
  - It drops on the cycle RESP completes or on timeout.
  - top uses it to gate the CPU's i_clk_ce.
- Undefined: the port is absent; the CPU runs freely and arbitration alone protects the bus.

Test Plan:
- Write: send 57 10 00 00 00 EF BE AD DE, grant 1 cycle after request -> one cycle with o_wr=F, o_addr=0x00000010, o_data_wr=0xDEADBEEF; TX emits 06.
- Read, RD_LATENCY=2: send 52 00 01 00 00; i_data_rd=0x12345678 in the sampled cycle -> o_rd high 3 cycles, o_addr=0x00000100; TX emits 78 56 34 12.
- Bad command: send 0x41 -> TX emits 15; bus idle; the following 'W' frame is executed normally.
- Timeout: send 57 10 00, then idle TIMEOUT_CYCLES -> state IDLE, no TX, no bus activity; the next 52 frame works.
- Backpressure and grant delay: i_bus_gnt held low 20 cycles, i_tx_ready low 50 cycles -> no strobe before grant; o_tx_data stable while o_tx_valid is waiting; correct bytes once ready.
- Reset during WAIT_RD: pull i_rst_n low -> o_rd, o_bus_req and o_tx_valid drop immediately; after release a full read frame completes.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
//   Debug/load bridge. Takes command frames from a UART receiver byte stream
//   and performs 32-bit accesses as a data-bus initiator, then answers over
//   the UART transmitter.
//     'W' addr[4] data[4] -> bus write, answers 0x06
//     'R' addr[4]         -> bus read, answers 4 data bytes LSB first
//     anything else       -> answers 0x15
//   Multi-byte fields are little-endian.
//
// Parameters
//   RD_LATENCY      cycles from o_rd assertion to valid i_data_rd (1..7)
//   TIMEOUT_CYCLES  inter-byte timeout inside a frame, in clock cycles
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_rx_data/i_rx_valid       received byte + one-cycle strobe
//   o_tx_data/o_tx_valid       byte to send, held until i_tx_ready
//   i_tx_ready                 transmitter accepts on valid && ready
//   o_bus_req/i_bus_gnt        arbiter handshake
//   o_addr/o_data_wr/o_wr/o_rd bus initiator outputs
//   i_data_rd                  bus read data
//   o_cpu_hold                 only with UART_BUS_BRIDGE_CPU_HOLD_EN defined:
//                              high from the first accepted byte of a W/R
//                              frame until its response completes or the
//                              frame times out
//
// Optional feature macro: UART_BUS_BRIDGE_CPU_HOLD_EN

module uart_bus_bridge #(
    parameter int unsigned RD_LATENCY     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
`ifdef UART_BUS_BRIDGE_CPU_HOLD_EN
    output logic        o_cpu_hold,
`endif
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_bus_req,
    input  logic        i_bus_gnt,
    output logic [31:0] o_addr,
    output logic [31:0] o_data_wr,
    output logic [3:0]  o_wr,
    output logic        o_rd,
    input  logic [31:0] i_data_rd
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_REQ     = 3'd3;
    localparam logic [2:0] S_ACCESS  = 3'd4;
    localparam logic [2:0] S_WAIT_RD = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]      state_q, state_d;
    logic            is_wr_q, is_wr_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;   // field byte index, then response byte index
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     resp_q, resp_d;
    logic [1:0]      resp_last_q, resp_last_d;
    logic [2:0]      lat_cnt_q, lat_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic            in_frame;
    logic            timeout;
    logic            resp_done;
    logic [7:0]      tx_byte;

    assign in_frame  = (state_q == S_ADDR) || (state_q == S_DATA);
    // A byte arriving in the expiry cycle takes precedence over the timeout.
    assign timeout   = in_frame && !i_rx_valid &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign resp_done = (state_q == S_RESP) && i_tx_ready && (byte_cnt_q == resp_last_q);

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_d      = resp_q;
        resp_last_d = resp_last_q;
        lat_cnt_d   = lat_cnt_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_rx_valid) begin
                    byte_cnt_d = 2'd0;
                    to_cnt_d   = '0;
                    if (i_rx_data == CMD_W || i_rx_data == CMD_R) begin
                        is_wr_d = (i_rx_data == CMD_W);
                        state_d = S_ADDR;
                    end else begin
                        resp_d      = {24'h0, RSP_NAK};
                        resp_last_d = 2'd0;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (i_rx_valid) begin
                    // Shifting in from the top leaves the first (LSB) byte in [7:0].
                    if (state_q == S_ADDR) addr_d  = {i_rx_data, addr_q[31:8]};
                    else                   wdata_d = {i_rx_data, wdata_q[31:8]};
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (state_q == S_ADDR && is_wr_q) ? S_DATA : S_REQ;
                    end
                end else if (timeout) begin
                    to_cnt_d   = '0;
                    byte_cnt_d = 2'd0;
                    state_d    = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_REQ: begin
                if (i_bus_gnt) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (is_wr_q) begin
                    resp_d      = {24'h0, RSP_ACK};
                    resp_last_d = 2'd0;
                    state_d     = S_RESP;
                end else begin
                    lat_cnt_d = 3'd1;
                    state_d   = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                // ACCESS was latency cycle 0; capture at cycle RD_LATENCY.
                if (lat_cnt_q == 3'(RD_LATENCY)) begin
                    resp_d      = i_data_rd;
                    resp_last_d = 2'd3;
                    state_d     = S_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                if (i_tx_ready) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == resp_last_q) begin
                        byte_cnt_d = 2'd0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            byte_cnt_q  <= 2'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            resp_q      <= 32'h0;
            resp_last_q <= 2'd0;
            lat_cnt_q   <= 3'd0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            resp_last_q <= resp_last_d;
            lat_cnt_q   <= lat_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (byte_cnt_q)
            2'd0: tx_byte = resp_q[7:0];
            2'd1: tx_byte = resp_q[15:8];
            2'd2: tx_byte = resp_q[23:16];
            2'd3: tx_byte = resp_q[31:24];
            default: tx_byte = 8'h00;
        endcase
    end

    // Bus outputs decode straight from the state register, so an asynchronous
    // reset removes any in-flight strobe immediately.
    assign o_bus_req  = (state_q == S_REQ) || (state_q == S_ACCESS) || (state_q == S_WAIT_RD);
    assign o_wr       = (state_q == S_ACCESS && is_wr_q) ? 4'hF : 4'h0;
    assign o_rd       = (state_q == S_ACCESS && !is_wr_q) || (state_q == S_WAIT_RD);
    assign o_addr     = (state_q == S_ACCESS || state_q == S_WAIT_RD) ? addr_q : 32'h0;
    assign o_data_wr  = (state_q == S_ACCESS && is_wr_q) ? wdata_q : 32'h0;
    assign o_tx_valid = (state_q == S_RESP);
    assign o_tx_data  = (state_q == S_RESP) ? tx_byte : 8'h00;

`ifdef UART_BUS_BRIDGE_CPU_HOLD_EN
    logic cpu_hold_q, cpu_hold_d;

    always_comb begin
        cpu_hold_d = cpu_hold_q;
        if (state_q == S_IDLE && i_rx_valid && (i_rx_data == CMD_W || i_rx_data == CMD_R)) begin
            cpu_hold_d = 1'b1;
        end else if (timeout || resp_done) begin
            cpu_hold_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cpu_hold_q <= 1'b0;
        else          cpu_hold_q <= cpu_hold_d;
    end

    assign o_cpu_hold = cpu_hold_q;
`else
    logic unused_resp_done;
    assign unused_resp_done = resp_done;
`endif

endmodule

// File: tb/tb_uart_bus_bridge.sv
module tb_uart_bus_bridge;
    localparam int RD_LAT = 2;
    localparam int TO_CYC = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [3:0]  wr;
    logic        rd;
    logic [31:0] data_rd = 32'h0;

    always #5 clk = ~clk;

    uart_bus_bridge #(.RD_LATENCY(RD_LAT), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_bus_req(bus_req), .i_bus_gnt(bus_gnt),
        .o_addr(addr), .o_data_wr(data_wr), .o_wr(wr), .o_rd(rd),
        .i_data_rd(data_rd)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: what memory should contain after the frames sent so far.
    logic [31:0] model_mem [logic [31:0]];
    // Bus slave memory, written only by the DUT's write strobes.
    logic [31:0] slave_mem [logic [31:0]];

    function automatic logic [31:0] dflt_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : dflt_word(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt_word(a);
    endfunction

    // Arbiter: grant gnt_delay cycles after the request is seen, hold until release.
    int gnt_delay = 0;
    int gnt_cnt   = 0;
    always @(negedge clk) begin
        if (!bus_req) begin
            bus_gnt = 1'b0;
            gnt_cnt = 0;
        end else if (!bus_gnt) begin
            if (gnt_cnt >= gnt_delay) bus_gnt = 1'b1;
            else gnt_cnt++;
        end
    end

    // Read slave: valid data only in the cycle RD_LAT after the first o_rd cycle.
    int   rd_age  = 0;
    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        if (rd) rd_age = prev_rd ? rd_age + 1 : 0;
        prev_rd = rd;
        if (rd && rd_age == RD_LAT) data_rd = slave_read(addr);
        else data_rd = $urandom;
    end

    // Bus monitor.
    int          wr_pulses = 0, rd_cycles = 0, req_rises = 0, bus_err = 0;
    logic [31:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
    logic        prev_wr = 1'b0, prev_req = 1'b0;
    always @(negedge clk) begin
        if (wr != 4'h0) begin
            wr_pulses++;
            wr_addr = addr;
            wr_data = data_wr;
            if (!bus_gnt || !bus_req || wr != 4'hF || prev_wr) bus_err++;
            slave_mem[addr] = data_wr;
        end
        if (rd) begin
            if (!bus_gnt || !bus_req) bus_err++;
            if (rd_cycles == 0) rd_addr = addr;
            else if (addr != rd_addr) bus_err++;
            rd_cycles++;
        end
        if (bus_req && !prev_req) req_rises++;
        prev_wr  = (wr != 4'h0);
        prev_req = bus_req;
    end

    int stable_err = 0;

    task automatic clear_counters();
        wr_pulses = 0; rd_cycles = 0; req_rises = 0; bus_err = 0; stable_err = 0;
    endtask

    // All tasks start and end at a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic collect(input int n, input int rdy_delay, output int ngot, output logic [31:0] word);
        int   cyc = 0;
        int   wait_cnt = 0;
        logic seen = 1'b0;
        logic [7:0] held = 8'h00;
        ngot = 0;
        word = 32'h0;
        while (ngot < n && cyc < 3000) begin
            if (tx_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = tx_data;
                end else if (tx_data !== held) begin
                    stable_err++;
                end
                if (wait_cnt >= rdy_delay) begin
                    tx_ready = 1'b1;
                    word[ngot*8 +: 8] = tx_data;
                    ngot++;
                    seen = 1'b0;
                    wait_cnt = 0;
                end else begin
                    tx_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                tx_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        check("tx_count", ngot, n);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                             input int gnt_dly, input int rdy_dly, input int gap, input bit inject);
        int          n_exp;
        logic [31:0] exp_word;
        int          ngot;
        logic [31:0] got;
        clear_counters();
        gnt_delay = gnt_dly;
        send_byte(cmd, gap);
        if (cmd == 8'h57 || cmd == 8'h52) begin
            for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8], (i == 3 && cmd == 8'h52) ? 0 : gap);
            if (cmd == 8'h57)
                for (int i = 0; i < 4; i++) send_byte(d[i*8 +: 8], (i == 3) ? 0 : gap);
        end
        if (inject) send_byte(8'h41, 0);
        if (cmd == 8'h57) begin
            n_exp = 1; exp_word = 32'h06;
            model_mem[a] = d;
        end else if (cmd == 8'h52) begin
            n_exp = 4; exp_word = model_read(a);
        end else begin
            n_exp = 1; exp_word = 32'h15;
        end
        collect(n_exp, rdy_dly, ngot, got);
        check("resp_bytes", got, exp_word);
        repeat (3) @(negedge clk);
        check("no_extra_tx", {31'h0, tx_valid}, 32'h0);
        if (cmd == 8'h57) begin
            check("wr_pulses", wr_pulses, 1);
            check("wr_addr", wr_addr, a);
            check("wr_data", wr_data, d);
            check("wr_no_rd", rd_cycles, 0);
        end else if (cmd == 8'h52) begin
            check("rd_cycles", rd_cycles, RD_LAT + 1);
            check("rd_addr", rd_addr, a);
            check("rd_no_wr", wr_pulses, 0);
        end else begin
            check("nak_no_bus", req_rises, 0);
        end
        check("bus_rules", bus_err, 0);
        check("tx_stable", stable_err, 0);
        $display("txn cmd=%02h addr=%08h data=%08h resp=%08h nbytes=%0d", cmd, a, d, got, ngot);
    endtask

    initial begin
        logic [31:0] pool [8];
        int          waited;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_wr", {28'h0, wr}, 32'h0);
        check("rst_rd", {31'h0, rd}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_data_wr", data_wr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed write, then read with preloaded memory.
        run_frame(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 0, 1'b0);
        slave_mem[32'h100] = 32'h1234_5678;
        model_mem[32'h100] = 32'h1234_5678;
        run_frame(8'h52, 32'h0000_0100, 32'h0, 1, 0, 0, 1'b0);

        // Bad command, then a normal write.
        run_frame(8'h41, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        run_frame(8'h57, 32'h0000_0203, 32'hCAFE_F00D, 0, 1, 0, 1'b0);

        // Timeout after a partial frame: exactly TO_CYC idle cycles.
        clear_counters();
        send_byte(8'h57, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, TO_CYC);
        check("to_no_tx", {31'h0, tx_valid}, 32'h0);
        check("to_no_bus", req_rises, 0);
        $display("txn partial frame 57 10 00 abandoned after %0d idle cycles", TO_CYC);
        run_frame(8'h52, 32'h0000_0010, 32'h0, 0, 0, 0, 1'b0);
        // Bytes arriving in the expiry cycle keep the frame alive.
        run_frame(8'h57, 32'h0000_0300, 32'h0BAD_CAFE, 0, 0, TO_CYC - 1, 1'b0);
        run_frame(8'h52, 32'h0000_0300, 32'h0, 0, 0, 0, 1'b0);

        // Grant delay, backpressure, and a stray byte dropped while in REQ.
        run_frame(8'h52, 32'h0000_0203, 32'h0, 20, 50, 0, 1'b1);

        // Reset during WAIT_RD.
        clear_counters();
        gnt_delay = 0;
        send_byte(8'h52, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h44, 0);
        waited = 0;
        while (!rd && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("rd_seen_before_rst", {31'h0, rd}, 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd", {31'h0, rd}, 32'h0);
        check("arst_bus_req", {31'h0, bus_req}, 32'h0);
        check("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("arst_addr", addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset asserted during read wait");
        run_frame(8'h52, 32'h0000_0100, 32'h0, 2, 1, 0, 1'b0);

        // Randomized frames against the memory model.
        for (int i = 0; i < 8; i++) pool[i] = {$urandom_range(0, 15), 28'h0} + 32'($urandom_range(0, 255));
        for (int t = 0; t < 40; t++) begin
            int          kind = $urandom_range(0, 9);
            logic [7:0]  c;
            logic [31:0] a = pool[$urandom_range(0, 7)];
            logic [31:0] d = $urandom;
            if (kind == 0) begin
                c = 8'($urandom);
                if (c == 8'h57 || c == 8'h52) c = 8'h00;
            end else if (kind <= 4) begin
                c = 8'h57;
            end else begin
                c = 8'h52;
            end
            run_frame(c, a, d, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
